// File: rtl/wb_stage.sv
// MEM/WB pipeline register with write-back commit logic.
// Latches the MEM-stage result, selects the write-back data at capture,
// and drives the register-file write port and the SP strobes.
// The strobes fire only in the first cycle an instruction is held,
// so a stalled instruction never writes twice or double-steps the SP.
// Also provides a forwarding tap and a retired-instruction counter.
module wb_stage #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              mem_valid,
    input  logic              mem_we,
    input  logic [1:0]        mem_rd,
    input  logic [1:0]        mem_wb_sel,
    input  logic [DATA_W-1:0] mem_alu,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [DATA_W-1:0] mem_inport,
    input  logic [DATA_W-1:0] mem_pc1,
    input  logic              mem_inc_sp,
    input  logic              mem_dec_sp,
    output logic              WE,
    output logic [1:0]        RW_addr,
    output logic [DATA_W-1:0] WD,
    output logic              IncSP,
    output logic              DecSP,
    output logic              fwd_valid,
    output logic [1:0]        fwd_addr,
    output logic [DATA_W-1:0] fwd_data,
    output logic              sp_conflict,
    output logic [CNT_W-1:0]  retired
);

    logic              validQ;
    logic              weQ;
    logic [1:0]        rdQ;
    logic [DATA_W-1:0] wdQ;
    logic              incQ;
    logic              decQ;
    logic              committedQ;
    logic              conflictQ;
    logic [CNT_W-1:0]  retiredQ;

    logic [DATA_W-1:0] wdMux;
    logic              r3Write;
    logic              incArb;
    logic              decArb;
    logic              conflictIn;
    logic              firstCycle;

    // Write-back source select, resolved before capture so WD comes straight from a flop
    always_comb begin
        wdMux = mem_alu;
        case (mem_wb_sel)
            2'b00:   wdMux = mem_alu;
            2'b01:   wdMux = mem_rdata;
            2'b10:   wdMux = mem_inport;
            2'b11:   wdMux = mem_pc1;
            default: wdMux = mem_alu;
        endcase
    end

    // SP arbitration: a GPR write to R3 beats any SP step, and decrement beats increment
    always_comb begin
        r3Write    = mem_we && (mem_rd == 2'd3);
        decArb     = mem_dec_sp && !r3Write;
        incArb     = mem_inc_sp && !mem_dec_sp && !r3Write;
        conflictIn = mem_valid && ((r3Write && (mem_inc_sp || mem_dec_sp))
                                   || (mem_inc_sp && mem_dec_sp));
    end

    // Stage register: flush loads a bubble, stall holds and marks the instruction as committed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            validQ     <= 1'b0;
            weQ        <= 1'b0;
            rdQ        <= 2'd0;
            wdQ        <= '0;
            incQ       <= 1'b0;
            decQ       <= 1'b0;
            committedQ <= 1'b0;
            conflictQ  <= 1'b0;
        end else if (flush) begin
            validQ     <= 1'b0;
            weQ        <= 1'b0;
            incQ       <= 1'b0;
            decQ       <= 1'b0;
            committedQ <= 1'b0;
            conflictQ  <= 1'b0;
        end else if (stall) begin
            committedQ <= committedQ || validQ;
        end else begin
            validQ     <= mem_valid;
            weQ        <= mem_we && mem_valid;
            rdQ        <= mem_rd;
            wdQ        <= wdMux;
            incQ       <= incArb && mem_valid;
            decQ       <= decArb && mem_valid;
            committedQ <= 1'b0;
            conflictQ  <= conflictIn;
        end
    end

    // Retired counter bumps when a valid instruction is loaded, so it is visible in its commit cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retiredQ <= '0;
        end else if (!flush && !stall && mem_valid) begin
            retiredQ <= retiredQ + CNT_W'(1);
        end
    end

    // Commit strobes are gated to the first held cycle; the forwarding tap stays up for the whole hold
    always_comb begin
        firstCycle  = validQ && !committedQ;
        WE          = firstCycle && weQ;
        IncSP       = firstCycle && incQ;
        DecSP       = firstCycle && decQ;
        RW_addr     = rdQ;
        WD          = wdQ;
        fwd_valid   = validQ && weQ;
        fwd_addr    = rdQ;
        fwd_data    = wdQ;
        sp_conflict = conflictQ;
        retired     = retiredQ;
    end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios followed by a
// randomized run, all compared against a behavioural model of the held instruction.
module tb_wb_stage;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst_n;
    logic              stall;
    logic              flush;
    logic              mem_valid;
    logic              mem_we;
    logic [1:0]        mem_rd;
    logic [1:0]        mem_wb_sel;
    logic [DATA_W-1:0] mem_alu;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] mem_inport;
    logic [DATA_W-1:0] mem_pc1;
    logic              mem_inc_sp;
    logic              mem_dec_sp;
    logic              WE;
    logic [1:0]        RW_addr;
    logic [DATA_W-1:0] WD;
    logic              IncSP;
    logic              DecSP;
    logic              fwd_valid;
    logic [1:0]        fwd_addr;
    logic [DATA_W-1:0] fwd_data;
    logic              sp_conflict;
    logic [CNT_W-1:0]  retired;

    int total = 0;
    int bad   = 0;

    // Behavioural model: the instruction currently held and how long it has been held
    bit mValid;
    bit mWe;
    bit mInc;
    bit mDec;
    int mRd;
    int mData;
    int mAge;
    int mRetired;

    int spCount = 100;
    int spBefore;
    int retiredBefore;

    wb_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_rd(mem_rd), .mem_wb_sel(mem_wb_sel),
        .mem_alu(mem_alu), .mem_rdata(mem_rdata), .mem_inport(mem_inport), .mem_pc1(mem_pc1),
        .mem_inc_sp(mem_inc_sp), .mem_dec_sp(mem_dec_sp),
        .WE(WE), .RW_addr(RW_addr), .WD(WD), .IncSP(IncSP), .DecSP(DecSP),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .sp_conflict(sp_conflict), .retired(retired)
    );

    // Free-running clock, posedge at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stand-in for the SP register, which steps on the negedge like the register file
    always @(negedge clk) begin
        if (rst_n) spCount = spCount + int'(IncSP) - int'(DecSP);
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mValid = 0; mWe = 0; mInc = 0; mDec = 0;
        mRd = 0; mData = 0; mAge = 0; mRetired = 0;
    endtask

    // Compare every output against what the held instruction implies
    task automatic checkAll(input string tag);
        bit first;
        bit r3;
        bit conf;
        first = mValid && (mAge == 0);
        r3    = mWe && (mRd == 3);
        conf  = mValid && ((r3 && (mInc || mDec)) || (mInc && mDec));
        checkOutput({tag, ".WE"}, int'(WE), int'(first && mWe));
        checkOutput({tag, ".IncSP"}, int'(IncSP), int'(first && mInc && !mDec && !r3));
        checkOutput({tag, ".DecSP"}, int'(DecSP), int'(first && mDec && !r3));
        checkOutput({tag, ".fwd_valid"}, int'(fwd_valid), int'(mValid && mWe));
        checkOutput({tag, ".sp_conflict"}, int'(sp_conflict), int'(conf));
        checkOutput({tag, ".retired"}, int'(retired), mRetired);
        if (mValid) begin
            checkOutput({tag, ".RW_addr"}, int'(RW_addr), mRd);
            checkOutput({tag, ".WD"}, int'(WD), mData);
            checkOutput({tag, ".fwd_addr"}, int'(fwd_addr), mRd);
            checkOutput({tag, ".fwd_data"}, int'(fwd_data), mData);
        end
    endtask

    // Drive one cycle of inputs, advance past the posedge and update the model
    task automatic applyStimulus(input bit st, input bit fl, input bit v, input bit we,
                                 input int rd, input int sel, input int alu, input int rdata,
                                 input int inport, input int pc1, input bit inc, input bit dec);
        stall      = st;
        flush      = fl;
        mem_valid  = v;
        mem_we     = we;
        mem_rd     = 2'(rd);
        mem_wb_sel = 2'(sel);
        mem_alu    = 8'(alu);
        mem_rdata  = 8'(rdata);
        mem_inport = 8'(inport);
        mem_pc1    = 8'(pc1);
        mem_inc_sp = inc;
        mem_dec_sp = dec;
        @(posedge clk);
        if (fl) begin
            mValid = 0;
            mAge   = 0;
        end else if (st) begin
            mAge++;
        end else begin
            mValid = v;
            mWe    = we;
            mRd    = rd;
            mInc   = inc;
            mDec   = dec;
            mAge   = 0;
            mData  = (sel == 0) ? alu : (sel == 1) ? rdata : (sel == 2) ? inport : pc1;
            if (v) mRetired = (mRetired + 1) % (1 << CNT_W);
        end
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulusIdle();
        modelReset();
        #2;
        checkAll("reset");
        #10 rst_n = 1'b1;

        // 1: ALU write to R1
        applyStimulus(0, 0, 1, 1, 1, 0, 8'h5A, 0, 0, 0, 0, 0);
        checkAll("alu");
        checkOutput("alu.WD_const", int'(WD), 8'h5A);
        checkOutput("alu.retired_const", int'(retired), 1);

        // 2: PUSH held by a 3-cycle stall
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkAll("push.first");
        checkOutput("push.DecSP_const", int'(DecSP), 1);
        spBefore      = spCount;
        retiredBefore = int'(retired);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 1, 1, 2, 0, 8'h77, 0, 0, 0, 1, 0);
            checkAll("push.stall");
        end
        checkOutput("push.sp_step", spCount, spBefore - 1);
        checkOutput("push.retired_once", int'(retired), retiredBefore);

        // 3: write to R3 collides with an SP decrement
        applyStimulus(0, 0, 1, 1, 3, 0, 8'hF0, 0, 0, 0, 0, 1);
        checkAll("r3conf");
        checkOutput("r3conf.sp_conflict_const", int'(sp_conflict), 1);

        // 4: flush beats stall
        retiredBefore = int'(retired);
        applyStimulus(1, 1, 1, 1, 1, 0, 8'h11, 0, 0, 0, 0, 0);
        checkAll("flush");
        checkOutput("flush.retired_same", int'(retired), retiredBefore);

        // 5: PC+1 then memory data back to back
        applyStimulus(0, 0, 1, 1, 2, 3, 0, 0, 0, 8'h23, 0, 0);
        checkAll("pc1");
        applyStimulus(0, 0, 1, 1, 2, 1, 0, 8'h99, 0, 0, 0, 0);
        checkAll("rdata");
        applyStimulus(0, 0, 1, 1, 0, 2, 0, 0, 8'h3C, 0, 0, 0);
        checkAll("inport");
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        checkAll("incdec");

        // Randomized run against the model
        for (int i = 0; i < 300; i++) begin
            applyStimulus($urandom_range(3) == 0, $urandom_range(9) == 0, $urandom_range(3) != 0,
                          1'($urandom), int'($urandom_range(3)), int'($urandom_range(3)),
                          int'($urandom_range(255)), int'($urandom_range(255)),
                          int'($urandom_range(255)), int'($urandom_range(255)),
                          $urandom_range(3) == 0, $urandom_range(3) == 0);
            checkAll("rand");
        end

        // 6: counter wrap after a fresh reset
        rst_n = 1'b0;
        #1;
        modelReset();
        checkAll("rst2");
        #3 rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            applyStimulus(0, 0, 1, 0, 0, 0, i, 0, 0, 0, 0, 0);
        end
        checkOutput("wrap.pre", int'(retired), 15);
        applyStimulus(0, 0, 1, 1, 1, 0, 8'h42, 0, 0, 0, 0, 0);
        checkAll("wrap");
        checkOutput("wrap.zero", int'(retired), 0);

        // Reset mid-stall clears everything immediately
        applyStimulus(0, 0, 1, 1, 3, 0, 8'hAB, 0, 0, 0, 1, 0);
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        modelReset();
        checkAll("midrst");
        checkOutput("midrst.WD", int'(WD), 0);
        checkOutput("midrst.RW_addr", int'(RW_addr), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    task automatic applyStimulusIdle();
        stall = 0; flush = 0; mem_valid = 0; mem_we = 0; mem_rd = 0; mem_wb_sel = 0;
        mem_alu = 0; mem_rdata = 0; mem_inport = 0; mem_pc1 = 0; mem_inc_sp = 0; mem_dec_sp = 0;
    endtask

endmodule
